ras_ctrl: RTL and testbench
===========================

# ras_ctrl

Sequencing controller in front of the return address stack. It accepts call (push) and return (pop) requests from frontend predecode over valid/ready handshakes and converts them into push/pop/flush strobes for the stack. It tracks stack occupancy and flags overflow and underflow. On a branch-prediction flush it clears the stack and holds off requests for a fixed quiet period.

## Interface
- CVA6Cfg, config_pkg::cva6_cfg_empty, core configuration; VLEN taken from it
- DEPTH, 2, entries in the controlled stack; must match the stack instance
- HOLD_CYCLES, 2, request-blocking cycles after each flush strobe; ≥1
- clk_i  in  1  clock
- rst_i  in  1  synchronous, active-high reset
- flush_i  in  1  flush request from controller (mispredict/fence)
- call_valid_i  in  1  call instruction present, push request
- call_addr_i  in  VLEN  return address to push
- call_ready_o  out  1  push accepted this cycle
- ret_valid_i  in  1  return instruction present, pop request
- ret_ready_o  out  1  pop accepted this cycle
- ret_addr_o  out  VLEN  predicted return target
- ret_addr_valid_o  out  1  ret_addr_o usable
- ras_ra_i  in  VLEN  stack top address
- ras_valid_i  in  1  stack top valid
- push_o / pop_o / flush_bp_o  out  1 each  stack strobes
- data_o  out  VLEN  push data to stack
- count_o  out  $clog2(DEPTH+1)  tracked occupancy
- overflow_o / underflow_o  out  1 each  single-cycle event pulses

## Operation
- FSM states: RUN, FLUSH, HOLD.
  - RUN: call_ready_o = ret_ready_o = 1.
  - FLUSH: flush_bp_o = 1, both readies 0; always advances to HOLD next cycle.
  - HOLD: readies 0. Down-counter loads HOLD_CYCLES-1 on entry and decrements each cycle. Exits to RUN after it reaches 0.
- flush_i in any state: next state is FLUSH. This restarts the sequence and overrides any pending request. In RUN the same-cycle handshake is still honoured, but the count is cleared anyway.
- Push accepted (call_valid_i & call_ready_o):
  - push_o = 1, data_o = call_addr_i.
  - count saturates at DEPTH.
  - A push at count == DEPTH pulses overflow_o; the stack discards its oldest entry.
- Pop accepted (ret_valid_i & ret_ready_o):
  - pop_o = 1 only if count != 0, and count decrements.
  - At count == 0 the pop is still accepted (ready stays 1), pop_o = 0, and underflow_o pulses.
- Push and pop accepted together: both strobes forwarded (stack replaces its top), count unchanged, no overflow or underflow.
- ret_addr_o = ras_ra_i always.
- ret_addr_valid_o = ras_valid_i & (count != 0) & (state == RUN).
- data_o = call_addr_i always; only push_o qualifies it.

## Timing
- Reset (rst_i = 1): state = FLUSH, count = 0, hold counter = 0, overflow_o = underflow_o = 0.
  - flush_bp_o is therefore 1 during reset and on the first cycle after release.
  - Then HOLD for HOLD_CYCLES cycles, then RUN.
  - First accept is possible HOLD_CYCLES+1 cycles after reset deasserts.
- push_o, pop_o, flush_bp_o and the readies are combinational from the state register and inputs, with zero latency to the stack.
- count_o is registered and reflects accepted operations from the next cycle.
- overflow_o / underflow_o are registered: asserted for exactly one cycle, the cycle after the offending handshake.
- Flush latency: flush_i at cycle N gives flush_bp_o = 1 at N+1 and readies back to 1 at N+2+HOLD_CYCLES.
- Reset mid-flush or mid-hold: returns to FLUSH, counter reloaded on HOLD entry.

## Structure
- Shared package (ras_pkg): ras_ctrl_state_e {RUN, FLUSH, HOLD}; ras_t struct {valid, ra[VLEN]} already used by the stack.
- One natural sub-module: ras_occ_counter, a saturating up/down counter (inc, dec, clr → count, ovf, unf). Everything else stays inline.

## Test plan
- Reset release:
  - flush_bp_o = 1 on first cycle; readies 0 for 1+HOLD_CYCLES cycles (3 with defaults); count_o = 0.
- Push 0x1000 then 0x2000 (DEPTH = 2), then a third push 0x3000:
  - count 1, 2, 2.
  - overflow_o pulses once, the cycle after the third push.
  - ret_addr_valid_o = 1, ret_addr_o tracks ras_ra_i (0x3000).
- Pop three times from count 2:
  - pop_o on first two only; count 1, 0, 0.
  - underflow_o pulse after the third; ret_addr_valid_o = 0 at count 0.
- Simultaneous call (0x4000) and ret at count 1:
  - push_o = pop_o = 1, data_o = 0x4000, count stays 1, no pulses.
- flush_i during HOLD (default params):
  - FSM re-enters FLUSH, flush_bp_o pulses again.
  - Readies return to 1 three cycles after the second flush_bp_o.
- flush_i coincident with an accepted push at count 1:
  - push_o = 1 that cycle, flush_bp_o = 1 next cycle, count_o = 0 after.

Source files
------------

// File: rtl/config_pkg.sv
// Minimal core-configuration package: only the fields this slice consumes.
package config_pkg;

   typedef struct packed {
      int unsigned VLEN;
   } cva6_cfg_t;

   localparam cva6_cfg_t cva6_cfg_empty = '{VLEN: 64};

endpackage

// File: rtl/ras_pkg.sv
// Shared return-address-stack types: controller states and the stack entry.
package ras_pkg;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      FLUSH = 2'd1,
      HOLD  = 2'd2
   } ras_ctrl_state_e;

   typedef struct packed {
      logic                                     valid;
      logic [config_pkg::cva6_cfg_empty.VLEN-1:0] ra;
   } ras_t;

endpackage

// File: rtl/ras_occ_counter.sv
// Saturating up/down occupancy counter with registered overflow/underflow pulses.
module ras_occ_counter #(
   parameter int unsigned DEPTH = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       clr,
   input  logic                       inc,
   input  logic                       dec,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       ovf,
   output logic                       unf
);

   localparam int unsigned CW = $clog2(DEPTH+1);
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   logic full;
   logic empty;

   assign full  = (count == FULL);
   assign empty = (count == '0);

   // Pulses follow the handshake even when a clear wipes the count.
   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
         ovf   <= 1'b0;
         unf   <= 1'b0;
      end else begin
         ovf <= inc & ~dec & full;
         unf <= dec & ~inc & empty;
         if (clr)
            count <= '0;
         else if (inc & ~dec & ~full)
            count <= count + 1'b1;
         else if (dec & ~inc & ~empty)
            count <= count - 1'b1;
      end
   end

endmodule

// File: rtl/ras_ctrl.sv
// Return-address-stack sequencer: call/ret handshakes to push/pop/flush strobes.
module ras_ctrl
   import ras_pkg::*;
#(
   parameter config_pkg::cva6_cfg_t CVA6Cfg     = config_pkg::cva6_cfg_empty,
   parameter int unsigned           DEPTH       = 2,
   parameter int unsigned           HOLD_CYCLES = 2
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       flush_i,
   input  logic                       call_valid_i,
   input  logic [CVA6Cfg.VLEN-1:0]    call_addr_i,
   output logic                       call_ready_o,
   input  logic                       ret_valid_i,
   output logic                       ret_ready_o,
   output logic [CVA6Cfg.VLEN-1:0]    ret_addr_o,
   output logic                       ret_addr_valid_o,
   input  logic [CVA6Cfg.VLEN-1:0]    ras_ra_i,
   input  logic                       ras_valid_i,
   output logic                       push_o,
   output logic                       pop_o,
   output logic                       flush_bp_o,
   output logic [CVA6Cfg.VLEN-1:0]    data_o,
   output logic [$clog2(DEPTH+1)-1:0] count_o,
   output logic                       overflow_o,
   output logic                       underflow_o
);

   localparam int unsigned HW = $clog2(HOLD_CYCLES+1);

   ras_ctrl_state_e state;
   logic [HW-1:0]   hold_cnt;
   logic            running;
   logic            call_acc;
   logic            ret_acc;

   assign running      = (state == RUN);
   assign call_ready_o = running;
   assign ret_ready_o  = running;
   assign flush_bp_o   = (state == FLUSH);
   assign call_acc     = call_valid_i & running;
   assign ret_acc      = ret_valid_i & running;

   assign push_o           = call_acc;
   assign pop_o            = ret_acc & (count_o != '0);
   assign data_o           = call_addr_i;
   assign ret_addr_o       = ras_ra_i;
   assign ret_addr_valid_o = ras_valid_i & (count_o != '0) & running;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state    <= FLUSH;
         hold_cnt <= '0;
      end else if (flush_i) begin
         state <= FLUSH;
      end else begin
         case (state)
            FLUSH: begin
               state    <= HOLD;
               hold_cnt <= HW'(HOLD_CYCLES - 1);
            end
            HOLD: begin
               if (hold_cnt == '0)
                  state <= RUN;
               else
                  hold_cnt <= hold_cnt - 1'b1;
            end
            RUN:     state <= RUN;
            default: state <= FLUSH;
         endcase
      end
   end

   ras_occ_counter #(
      .DEPTH(DEPTH)
   ) u_occ (
      .clk  (clk_i),
      .rst  (rst_i),
      .clr  (flush_i),
      .inc  (call_acc),
      .dec  (ret_acc),
      .count(count_o),
      .ovf  (overflow_o),
      .unf  (underflow_o)
   );

endmodule

// File: tb/tb_ras_ctrl.sv
// Scoreboard bench for ras_ctrl: directed scenarios then randomized traffic.
module tb_ras_ctrl;

   localparam int unsigned V  = config_pkg::cva6_cfg_empty.VLEN;
   localparam int unsigned D  = 2;
   localparam int unsigned H  = 2;
   localparam int unsigned CW = $clog2(D+1);

   logic          clk = 1'b0;
   logic          rst_i, flush_i, call_valid_i, ret_valid_i, ras_valid_i;
   logic [V-1:0]  call_addr_i, ras_ra_i;
   logic          call_ready_o, ret_ready_o, ret_addr_valid_o;
   logic          push_o, pop_o, flush_bp_o, overflow_o, underflow_o;
   logic [V-1:0]  ret_addr_o, data_o;
   logic [CW-1:0] count_o;

   always #5 clk = ~clk;

   ras_ctrl #(
      .CVA6Cfg    (config_pkg::cva6_cfg_empty),
      .DEPTH      (D),
      .HOLD_CYCLES(H)
   ) dut (
      .clk_i           (clk),
      .rst_i           (rst_i),
      .flush_i         (flush_i),
      .call_valid_i    (call_valid_i),
      .call_addr_i     (call_addr_i),
      .call_ready_o    (call_ready_o),
      .ret_valid_i     (ret_valid_i),
      .ret_ready_o     (ret_ready_o),
      .ret_addr_o      (ret_addr_o),
      .ret_addr_valid_o(ret_addr_valid_o),
      .ras_ra_i        (ras_ra_i),
      .ras_valid_i     (ras_valid_i),
      .push_o          (push_o),
      .pop_o           (pop_o),
      .flush_bp_o      (flush_bp_o),
      .data_o          (data_o),
      .count_o         (count_o),
      .overflow_o      (overflow_o),
      .underflow_o     (underflow_o)
   );

   typedef struct {
      bit           push, pop, fbp, cr, rr, ovf, unf, rav;
      logic [V-1:0] data, ra;
      int           cnt;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   // Reference model: quiet = cycles left with readies low (H+1 covers the flush cycle).
   int occ   = 0;
   int quiet = 0;
   bit ovf_m = 0;
   bit unf_m = 0;
   bit known = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, req);
      end
   endtask

   task automatic step(input bit rst, input bit fl, input bit cv, input logic [V-1:0] ca,
                       input bit rv, input bit rav, input logic [V-1:0] ra);
      exp_t e;
      bit   rdy, c_acc, r_acc;
      rst_i = rst; flush_i = fl; call_valid_i = cv; call_addr_i = ca;
      ret_valid_i = rv; ras_valid_i = rav; ras_ra_i = ra;
      rdy   = (quiet == 0);
      c_acc = cv && rdy;
      r_acc = rv && rdy;
      if (known) begin
         e.cr   = rdy;
         e.rr   = rdy;
         e.fbp  = (quiet == H + 1);
         e.push = c_acc;
         e.pop  = r_acc && (occ > 0);
         e.data = ca;
         e.ra   = ra;
         e.cnt  = occ;
         e.ovf  = ovf_m;
         e.unf  = unf_m;
         e.rav  = rav && (occ > 0) && rdy;
         exp_q.push_back(e);
      end
      if (rst) begin
         occ = 0; quiet = H + 1; ovf_m = 0; unf_m = 0; known = 1;
      end else begin
         ovf_m = c_acc && !r_acc && (occ == D);
         unf_m = r_acc && !c_acc && (occ == 0);
         if (fl)                  occ = 0;
         else if (c_acc && !r_acc) occ = (occ == D) ? D : occ + 1;
         else if (r_acc && !c_acc) occ = (occ == 0) ? 0 : occ - 1;
         quiet = fl ? H + 1 : ((quiet > 0) ? quiet - 1 : 0);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n, input logic [V-1:0] ra);
      for (int i = 0; i < n; i++) step(0, 0, 0, '0, 0, 1, ra);
   endtask

   // Monitor: every cycle presents outputs; compare against the queued expectation.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("push_o",           64'(push_o),           64'(e.push));
            chk("pop_o",            64'(pop_o),            64'(e.pop));
            chk("flush_bp_o",       64'(flush_bp_o),       64'(e.fbp));
            chk("call_ready_o",     64'(call_ready_o),     64'(e.cr));
            chk("ret_ready_o",      64'(ret_ready_o),      64'(e.rr));
            chk("data_o",           64'(data_o),           64'(e.data));
            chk("ret_addr_o",       64'(ret_addr_o),       64'(e.ra));
            chk("count_o",          64'(count_o),          64'(e.cnt));
            chk("overflow_o",       64'(overflow_o),       64'(e.ovf));
            chk("underflow_o",      64'(underflow_o),      64'(e.unf));
            chk("ret_addr_valid_o", 64'(ret_addr_valid_o), 64'(e.rav));
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "timeout");
   end

   initial begin
      logic [V-1:0] a;
      step(1, 0, 0, '0, 0, 0, '0);
      step(1, 0, 0, '0, 0, 0, '0);
      idle(4, 64'h0);
      // Fill past DEPTH, then drain past empty.
      step(0, 0, 1, 64'h1000, 0, 1, 64'h0);
      step(0, 0, 1, 64'h2000, 0, 1, 64'h1000);
      step(0, 0, 1, 64'h3000, 0, 1, 64'h2000);
      idle(2, 64'h3000);
      step(0, 0, 0, '0, 1, 1, 64'h3000);
      step(0, 0, 0, '0, 1, 1, 64'h2000);
      step(0, 0, 0, '0, 1, 1, 64'h0);
      idle(2, 64'h0);
      // Simultaneous call and ret at count 1.
      step(0, 0, 1, 64'h5000, 0, 1, 64'h0);
      step(0, 0, 1, 64'h4000, 1, 1, 64'h5000);
      idle(2, 64'h4000);
      // Flush, then flush again during HOLD.
      step(0, 1, 0, '0, 0, 1, 64'h4000);
      step(0, 0, 0, '0, 0, 1, 64'h0);
      step(0, 0, 0, '0, 0, 1, 64'h0);
      step(0, 1, 0, '0, 0, 1, 64'h0);
      idle(6, 64'h0);
      // Flush coincident with an accepted push at count 1.
      step(0, 0, 1, 64'h6000, 0, 1, 64'h0);
      step(0, 1, 1, 64'h7000, 0, 1, 64'h6000);
      idle(6, 64'h7000);
      // Reset in the middle of HOLD.
      step(0, 1, 0, '0, 0, 1, 64'h0);
      step(0, 0, 0, '0, 0, 1, 64'h0);
      step(1, 0, 0, '0, 0, 1, 64'h0);
      idle(5, 64'h0);
      for (int i = 0; i < 3000; i++) begin
         a = {$urandom, $urandom};
         step($urandom_range(0, 299) == 0, $urandom_range(0, 39) == 0,
              1'($urandom_range(0, 1)), a, 1'($urandom_range(0, 1)),
              $urandom_range(0, 3) != 0, {$urandom, $urandom});
      end
      @(negedge clk);
      chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
